pipeline_hazard_controller: RTL and testbench

PIPELINE_HAZARD_CONTROLLER -- requirements
Module: pipeline_hazard_controller

---
 rtl/pipeline_hazard_controller.sv | 118 +++++++++++
 tb/tb_pipeline_hazard_controller.sv | 128 ++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_controller.sv
// Hazard/stall/flush controller for a 5-stage in-order pipeline.
// Optional ID-stage branch operand stall enabled by `define BRANCH_HAZARD_EN.
module pipeline_hazard_controller #(
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [5:0]             id_op_code,
    input  logic [4:0]             id_rs,
    input  logic [4:0]             id_rt,
    input  logic                   ex_mem_read,
    input  logic                   ex_reg_write,
    input  logic [4:0]             ex_dest,
    input  logic                   branch_taken,
    input  logic                   jump,
    output logic                   hold,
    output logic                   flush_if_id,
    output logic                   bubble_id_ex,
    output logic [1:0]             state,
    output logic [STALL_CNT_W-1:0] stall_count
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2,
        BAD   = 2'd3
    } state_t;

    state_t st, st_nx;
    logic   rem, rem_nx;
    logic   reads_rt, rs_hit, rt_hit;
    logic   load_use, br_haz;
    logic   hold_c, flush_c, bub_c;

    always_comb begin
        reads_rt = 1'b0;
        case (id_op_code)
            6'h00, 6'h04, 6'h05, 6'h2B: reads_rt = 1'b1;
            default:                    reads_rt = 1'b0;
        endcase
    end

    assign rs_hit   = (ex_dest != 5'd0) && (ex_dest == id_rs);
    assign rt_hit   = (ex_dest != 5'd0) && (ex_dest == id_rt);
    assign load_use = ex_mem_read && (rs_hit || (reads_rt && rt_hit));

`ifdef BRANCH_HAZARD_EN
    // Branches compare in ID, so both operands are needed there.
    assign br_haz = ((id_op_code == 6'h04) || (id_op_code == 6'h05))
                    && ex_reg_write && (rs_hit || rt_hit);
`else
    logic unused_reg_write;
    assign unused_reg_write = ex_reg_write;
    assign br_haz = 1'b0;
`endif

    always_comb begin
        hold_c  = 1'b0;
        flush_c = 1'b0;
        bub_c   = 1'b0;
        st_nx   = st;
        rem_nx  = rem;
        case (st)
            RUN: begin
                if (br_haz) begin
                    hold_c = 1'b1;
                    bub_c  = 1'b1;
                    st_nx  = STALL;
                    rem_nx = ex_mem_read;
                end else if (load_use) begin
                    hold_c = 1'b1;
                    bub_c  = 1'b1;
                end else if (branch_taken || jump) begin
                    flush_c = 1'b1;
                    st_nx   = FLUSH;
                end
            end
`ifdef BRANCH_HAZARD_EN
            STALL: begin
                hold_c = 1'b1;
                bub_c  = 1'b1;
                if (rem) rem_nx = 1'b0;
                else     st_nx  = RUN;
            end
`endif
            FLUSH: st_nx = RUN;
            default: begin
                st_nx  = RUN;
                rem_nx = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st  <= RUN;
            rem <= 1'b0;
        end else begin
            st  <= st_nx;
            rem <= rem_nx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_count <= '0;
        else if (hold && (stall_count != '1))
            stall_count <= stall_count + 1'b1;
    end

    // Outputs are masked during reset so a held-over state cannot leak.
    assign hold         = hold_c  & ~rst;
    assign flush_if_id  = flush_c & ~rst;
    assign bubble_id_ex = bub_c   & ~rst;
    assign state        = st;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Scoreboard bench for pipeline_hazard_controller (4-bit stall counter).
// Directed vectors; monitor checks outputs mid-cycle against queued values.
module tb_pipeline_hazard_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] id_op_code = '0;
    logic [4:0] id_rs = '0, id_rt = '0, ex_dest = '0;
    logic       ex_mem_read = 1'b0, ex_reg_write = 1'b0;
    logic       branch_taken = 1'b0, jump = 1'b0;
    logic       hold, flush_if_id, bubble_id_ex;
    logic [1:0] state;
    logic [3:0] stall_count;

    typedef struct {
        string      name;
        logic       h, f, b;
        logic [1:0] s;
        logic [3:0] c;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;
    bit   done = 1'b0;

    pipeline_hazard_controller #(.STALL_CNT_W(4)) dut (
        .clk(clk), .rst(rst),
        .id_op_code(id_op_code), .id_rs(id_rs), .id_rt(id_rt),
        .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write),
        .ex_dest(ex_dest), .branch_taken(branch_taken), .jump(jump),
        .hold(hold), .flush_if_id(flush_if_id),
        .bubble_id_ex(bubble_id_ex), .state(state),
        .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    task automatic step(
        input string      nm,
        input logic       r,
        input logic [5:0] op,
        input logic [4:0] rs, rt,
        input logic       mr, rw,
        input logic [4:0] dst,
        input logic       bt, j,
        input logic       eh, ef, eb,
        input logic [1:0] es,
        input logic [3:0] ec
    );
        exp_t x;
        @(posedge clk);
        #1;
        rst = r; id_op_code = op; id_rs = rs; id_rt = rt;
        ex_mem_read = mr; ex_reg_write = rw; ex_dest = dst;
        branch_taken = bt; jump = j;
        x.name = nm; x.h = eh; x.f = ef; x.b = eb; x.s = es; x.c = ec;
        q.push_back(x);
    endtask

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                checks++;
                if ({hold, flush_if_id, bubble_id_ex, state, stall_count}
                    !== {e.h, e.f, e.b, e.s, e.c}) begin
                    errors++;
                    $display("FAIL %s: got h%0b f%0b b%0b st%0d cnt%0d want h%0b f%0b b%0b st%0d cnt%0d",
                             e.name, hold, flush_if_id, bubble_id_ex, state,
                             stall_count, e.h, e.f, e.b, e.s, e.c);
                end
            end
        end
    end

    initial begin : stim
        step("rst_hold",  1, 6'h00, 1, 5, 1, 0, 5, 1, 0,  0, 0, 0, 0, 0);
        step("idle0",     0, 6'h08, 1, 2, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0);
        step("lu_rt",     0, 6'h00, 1, 5, 1, 0, 5, 0, 0,  1, 0, 1, 0, 0);
        step("lu_after",  0, 6'h08, 1, 2, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1);
        step("lu_r0",     0, 6'h00, 0, 0, 1, 0, 0, 0, 0,  0, 0, 0, 0, 1);
        step("lw_rt",     0, 6'h23, 1, 7, 1, 0, 7, 0, 0,  0, 0, 0, 0, 1);
        step("sw_rt",     0, 6'h2B, 1, 7, 1, 0, 7, 0, 0,  1, 0, 1, 0, 1);
        step("lu_rs",     0, 6'h08, 9, 2, 1, 0, 9, 0, 0,  1, 0, 1, 0, 2);
        step("bt_flush",  0, 6'h08, 1, 2, 0, 0, 0, 1, 0,  0, 1, 0, 0, 3);
        step("flush_ign", 0, 6'h00, 1, 5, 1, 0, 5, 1, 0,  0, 0, 0, 2, 3);
        step("flush_ret", 0, 6'h08, 1, 2, 0, 0, 0, 0, 0,  0, 0, 0, 0, 3);
        step("lu_jump",   0, 6'h00, 1, 5, 1, 0, 5, 0, 1,  1, 0, 1, 0, 3);
        step("jump",      0, 6'h08, 1, 2, 0, 0, 0, 0, 1,  0, 1, 0, 0, 4);
        step("jump_fl",   0, 6'h08, 1, 2, 0, 0, 0, 0, 0,  0, 0, 0, 2, 4);
`ifndef BRANCH_HAZARD_EN
        step("br_nohaz",  0, 6'h04, 3, 4, 0, 1, 3, 0, 0,  0, 0, 0, 0, 4);
`endif
        for (int i = 0; i < 13; i++)
            step("sat", 0, 6'h00, 1, 5, 1, 0, 5, 0, 0, 1, 0, 1, 0,
                 (i < 11) ? 4'(4 + i) : 4'd15);
        step("sat_hold",  0, 6'h08, 1, 2, 0, 0, 0, 0, 0,  0, 0, 0, 0, 15);
        step("arst",      1, 6'h00, 1, 5, 1, 0, 5, 1, 0,  0, 0, 0, 0, 0);
        step("arst2",     1, 6'h00, 1, 5, 1, 0, 5, 0, 1,  0, 0, 0, 0, 0);
        step("rel",       0, 6'h08, 1, 2, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0);
        step("lu_rel",    0, 6'h00, 1, 5, 1, 0, 5, 0, 0,  1, 0, 1, 0, 0);
        step("idle1",     0, 6'h08, 1, 2, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1);
`ifdef BRANCH_HAZARD_EN
        step("br_alu",    0, 6'h04, 3, 4, 0, 1, 3, 0, 0,  1, 0, 1, 0, 1);
        step("br_alu_s",  0, 6'h04, 3, 4, 0, 0, 0, 1, 0,  1, 0, 1, 1, 2);
        step("br_alu_d",  0, 6'h08, 1, 2, 0, 0, 0, 0, 0,  0, 0, 0, 0, 3);
        step("br_ld",     0, 6'h05, 3, 4, 1, 1, 3, 0, 0,  1, 0, 1, 0, 3);
        step("br_ld_s1",  0, 6'h05, 3, 4, 0, 0, 0, 0, 0,  1, 0, 1, 1, 4);
        step("br_ld_s2",  0, 6'h05, 3, 4, 0, 0, 0, 0, 0,  1, 0, 1, 1, 5);
        step("br_ld_d",   0, 6'h08, 1, 2, 0, 0, 0, 0, 0,  0, 0, 0, 0, 6);
        step("br_ld2",    0, 6'h05, 3, 4, 1, 1, 3, 0, 0,  1, 0, 1, 0, 6);
        step("stl_rst",   1, 6'h05, 3, 4, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0);
        step("stl_rel",   0, 6'h08, 1, 2, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0);
`endif
        repeat (2) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
